// File: rtl/hazard_stall_unit.sv
// Stall/halt controller for the no-forwarding 5-stage pipeline: RAW scoreboard over EX/MEM/WB
// plus HALT drain sequencing.
module hazard_stall_unit #(
    parameter int unsigned DATA    = 32,
    parameter int unsigned REGADDR = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               id_valid,
    input  logic [REGADDR-1:0] id_rs,
    input  logic [REGADDR-1:0] id_rt,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic [REGADDR-1:0] id_rd,
    input  logic               id_writes_reg,
    input  logic               id_is_halt,
    input  logic               branchTaken,
    output logic               hazardDetected,
    output logic               haltSignal,
    output logic               flush_ifid,
    output logic               bubble_idex,
    output logic               pipe_done,
    output logic [DATA-1:0]    stall_count
);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_t;

    state_t state_q, state_d;

    logic               ex_wr_q, ex_halt_q;
    logic [REGADDR-1:0] ex_rd_q;
    logic               mem_wr_q, mem_halt_q;
    logic [REGADDR-1:0] mem_rd_q;
    // WB only ever needs its halt bit: the register file resolves WB-to-ID in the same cycle.
    logic               wb_halt_q;

    logic               halt_q, done_q;
    logic [DATA-1:0]    count_q;

    logic run, ex_match, mem_match, issue;

    assign run = (state_q == StRun);

    assign ex_match = ex_wr_q && (ex_rd_q != '0) &&
                      ((id_uses_rs && (id_rs == ex_rd_q)) || (id_uses_rt && (id_rt == ex_rd_q)));
    assign mem_match = mem_wr_q && (mem_rd_q != '0) &&
                       ((id_uses_rs && (id_rs == mem_rd_q)) || (id_uses_rt && (id_rt == mem_rd_q)));

    assign hazardDetected = id_valid && run && !branchTaken && (ex_match || mem_match);
    assign flush_ifid     = branchTaken && run;
    assign bubble_idex    = hazardDetected || flush_ifid || !run;
    assign issue          = id_valid && run && !hazardDetected && !branchTaken;

    assign haltSignal  = halt_q;
    assign pipe_done   = done_q;
    assign stall_count = count_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:    if (issue && id_is_halt) state_d = StDrain;
            StDrain:  if (wb_halt_q) state_d = StHalted;
            StHalted: state_d = StHalted;
            default:  state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StRun;
            ex_wr_q    <= 1'b0;
            ex_rd_q    <= '0;
            ex_halt_q  <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_rd_q   <= '0;
            mem_halt_q <= 1'b0;
            wb_halt_q  <= 1'b0;
            halt_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            ex_wr_q    <= issue && id_writes_reg && (id_rd != '0) && !id_is_halt;
            ex_rd_q    <= issue ? id_rd : '0;
            ex_halt_q  <= issue && id_is_halt;
            mem_wr_q   <= ex_wr_q;
            mem_rd_q   <= ex_rd_q;
            mem_halt_q <= ex_halt_q;
            wb_halt_q  <= mem_halt_q;
            halt_q     <= halt_q || (issue && id_is_halt);
            done_q     <= (state_d == StHalted);
            if (hazardDetected && (count_q != '1)) begin
                count_q <= count_q + DATA'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit; a 2-bit-counter instance covers saturation.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_uses_rs, id_uses_rt, id_writes_reg, id_is_halt;
    logic       branchTaken;
    logic       hazardDetected, haltSignal, flush_ifid, bubble_idex, pipe_done;
    logic [31:0] stall_count;
    logic       s_hazard, s_halt, s_flush, s_bubble, s_done;
    logic [1:0] s_count;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.DATA(32), .REGADDR(5)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_writes_reg(id_writes_reg), .id_is_halt(id_is_halt), .branchTaken(branchTaken),
        .hazardDetected(hazardDetected), .haltSignal(haltSignal), .flush_ifid(flush_ifid),
        .bubble_idex(bubble_idex), .pipe_done(pipe_done), .stall_count(stall_count)
    );

    hazard_stall_unit #(.DATA(2), .REGADDR(5)) dut_sat (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_writes_reg(id_writes_reg), .id_is_halt(id_is_halt), .branchTaken(branchTaken),
        .hazardDetected(s_hazard), .haltSignal(s_halt), .flush_ifid(s_flush),
        .bubble_idex(s_bubble), .pipe_done(s_done), .stall_count(s_count)
    );

    task automatic set_id(input logic v, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                          input logic wr, input logic halt);
        id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        id_rd = rd; id_writes_reg = wr; id_is_halt = halt;
        #1;
    endtask

    task automatic idle();
        branchTaken = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_pipe();
        idle();
        repeat (3) step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        #3;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        #2;
        n_checks++; if (hazardDetected !== 1'b0) begin n_fail++; $display("FAIL reset_hazard got %b want 0", hazardDetected); end
        n_checks++; if (haltSignal !== 1'b0) begin n_fail++; $display("FAIL reset_halt got %b want 0", haltSignal); end
        n_checks++; if (pipe_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", pipe_done); end
        n_checks++; if (stall_count !== 32'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", stall_count); end
        n_checks++; if ({flush_ifid, bubble_idex} !== 2'b00) begin n_fail++; $display("FAIL reset_flush_bubble got %b want 00", {flush_ifid, bubble_idex}); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_ex_stall();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);  // add r3
        n_checks++; if (hazardDetected !== 1'b0) begin n_fail++; $display("FAIL ex_first got %b want 0", hazardDetected); end
        step();
        set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0);  // sub r6, r3, r4
        n_checks++; if ({hazardDetected, bubble_idex, flush_ifid} !== 3'b110) begin n_fail++; $display("FAIL ex_stall1 got %b want 110", {hazardDetected, bubble_idex, flush_ifid}); end
        step();
        n_checks++; if ({hazardDetected, bubble_idex} !== 2'b11) begin n_fail++; $display("FAIL ex_stall2 got %b want 11", {hazardDetected, bubble_idex}); end
        n_checks++; if (stall_count !== 32'd1) begin n_fail++; $display("FAIL ex_count1 got %0d want 1", stall_count); end
        step();
        n_checks++; if ({hazardDetected, bubble_idex} !== 2'b00) begin n_fail++; $display("FAIL ex_release got %b want 00", {hazardDetected, bubble_idex}); end
        step();
        n_checks++; if (stall_count !== 32'd2) begin n_fail++; $display("FAIL ex_count2 got %0d want 2", stall_count); end
        n_checks++; if (s_count !== 2'd2) begin n_fail++; $display("FAIL sat_pre got %0d want 2", s_count); end
    endtask

    task automatic test_saturation();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd14, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0);
        n_checks++; if (hazardDetected !== 1'b1) begin n_fail++; $display("FAIL sat_haz got %b want 1", hazardDetected); end
        step();
        n_checks++; if (s_count !== 2'd3) begin n_fail++; $display("FAIL sat_a got %0d want 3", s_count); end
        step();
        n_checks++; if (s_count !== 2'd3) begin n_fail++; $display("FAIL sat_b got %0d want 3", s_count); end
        step();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd15, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd21, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 5'd22, 1'b1, 1'b0);
        step();
        n_checks++; if (s_count !== 2'd3) begin n_fail++; $display("FAIL sat_c got %0d want 3", s_count); end
        n_checks++; if (stall_count !== 32'd5) begin n_fail++; $display("FAIL sat_main got %0d want 5", stall_count); end
        step();
    endtask

    task automatic test_mem_wb();
        flush_pipe();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);  // lw r5
        step();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
        n_checks++; if (hazardDetected !== 1'b0) begin n_fail++; $display("FAIL mem_unrel got %b want 0", hazardDetected); end
        step();
        set_id(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0);
        n_checks++; if (hazardDetected !== 1'b1) begin n_fail++; $display("FAIL mem_stall got %b want 1", hazardDetected); end
        step();
        n_checks++; if (hazardDetected !== 1'b0) begin n_fail++; $display("FAIL mem_release got %b want 0", hazardDetected); end
        n_checks++; if (stall_count !== 32'd6) begin n_fail++; $display("FAIL mem_count got %0d want 6", stall_count); end
        step();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);  // lw r9
        step();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd12, 1'b1, 1'b0);
        n_checks++; if (hazardDetected !== 1'b0) begin n_fail++; $display("FAIL wb_nostall got %b want 0", hazardDetected); end
        step();
    endtask

    task automatic test_reg0();
        flush_pipe();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd23, 1'b1, 1'b0);
        n_checks++; if (hazardDetected !== 1'b0) begin n_fail++; $display("FAIL r0_read got %b want 0", hazardDetected); end
        step();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd12, 1'b0, 5'd13, 1'b1, 5'd24, 1'b1, 1'b0);
        n_checks++; if (hazardDetected !== 1'b0) begin n_fail++; $display("FAIL unused_rs got %b want 0", hazardDetected); end
        step();
        n_checks++; if (stall_count !== 32'd6) begin n_fail++; $display("FAIL r0_count got %0d want 6", stall_count); end
    endtask

    task automatic test_branch();
        flush_pipe();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd17, 1'b1, 1'b0);
        step();
        branchTaken = 1'b1;
        set_id(1'b1, 5'd17, 1'b1, 5'd0, 1'b0, 5'd18, 1'b1, 1'b0);
        n_checks++; if ({hazardDetected, flush_ifid, bubble_idex} !== 3'b011) begin n_fail++; $display("FAIL br_prio got %b want 011", {hazardDetected, flush_ifid, bubble_idex}); end
        step();
        branchTaken = 1'b0;
        set_id(1'b1, 5'd18, 1'b1, 5'd0, 1'b0, 5'd25, 1'b1, 1'b0);
        n_checks++; if (hazardDetected !== 1'b0) begin n_fail++; $display("FAIL br_ex_empty got %b want 0", hazardDetected); end
        n_checks++; if (stall_count !== 32'd6) begin n_fail++; $display("FAIL br_count got %0d want 6", stall_count); end
        step();
    endtask

    task automatic test_halt();
        flush_pipe();
        branchTaken = 1'b1;
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        step();
        idle();
        repeat (3) step();
        n_checks++; if ({haltSignal, pipe_done, bubble_idex} !== 3'b000) begin n_fail++; $display("FAIL halt_wrongpath got %b want 000", {haltSignal, pipe_done, bubble_idex}); end
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        n_checks++; if ({haltSignal, bubble_idex} !== 2'b00) begin n_fail++; $display("FAIL halt_pre got %b want 00", {haltSignal, bubble_idex}); end
        step();  // edge N
        n_checks++; if ({haltSignal, pipe_done} !== 2'b10) begin n_fail++; $display("FAIL halt_n got %b want 10", {haltSignal, pipe_done}); end
        branchTaken = 1'b1;
        set_id(1'b1, 5'd17, 1'b1, 5'd0, 1'b0, 5'd26, 1'b1, 1'b0);
        n_checks++; if ({hazardDetected, flush_ifid, bubble_idex} !== 3'b001) begin n_fail++; $display("FAIL drain_ctrl got %b want 001", {hazardDetected, flush_ifid, bubble_idex}); end
        step();
        n_checks++; if (pipe_done !== 1'b0) begin n_fail++; $display("FAIL done_n1 got %b want 0", pipe_done); end
        step();
        n_checks++; if ({haltSignal, pipe_done} !== 2'b10) begin n_fail++; $display("FAIL done_n2 got %b want 10", {haltSignal, pipe_done}); end
        step();
        n_checks++; if ({haltSignal, pipe_done} !== 2'b11) begin n_fail++; $display("FAIL done_n3 got %b want 11", {haltSignal, pipe_done}); end
        idle();
        repeat (2) step();
        n_checks++; if ({haltSignal, pipe_done, bubble_idex} !== 3'b111) begin n_fail++; $display("FAIL halted_hold got %b want 111", {haltSignal, pipe_done, bubble_idex}); end
    endtask

    task automatic test_reset_drain();
        do_reset();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd20, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd27, 1'b1, 1'b0);
        repeat (3) step();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        step();
        n_checks++; if ({haltSignal, bubble_idex} !== 2'b11) begin n_fail++; $display("FAIL rd_drain got %b want 11", {haltSignal, bubble_idex}); end
        n_checks++; if (stall_count !== 32'd2) begin n_fail++; $display("FAIL rd_count got %0d want 2", stall_count); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if ({haltSignal, pipe_done, bubble_idex} !== 3'b000) begin n_fail++; $display("FAIL rd_async got %b want 000", {haltSignal, pipe_done, bubble_idex}); end
        n_checks++; if (stall_count !== 32'd0) begin n_fail++; $display("FAIL rd_async_count got %0d want 0", stall_count); end
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        step();
        n_checks++; if ({haltSignal, pipe_done, bubble_idex} !== 3'b000) begin n_fail++; $display("FAIL rd_run got %b want 000", {haltSignal, pipe_done, bubble_idex}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ex_stall();
        test_saturation();
        test_mem_wb();
        test_reg0();
        test_branch();
        test_halt();
        test_reset_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall/halt controller for the no-forwarding MIPS-Lite 5-stage pipeline.
- Drives the program counter's `hazardDetected` and `haltSignal` inputs, plus IF/ID flush and ID/EX bubble controls.
- Keeps a 3-entry scoreboard of in-flight destination registers (EX, MEM, WB). It stalls ID on RAW dependencies and sequences HALT drain to completion.
- Sits between the ID-stage decoder, the EX-stage branch resolver and the PC/pipeline registers.

Parameters:
- DATA, 32, width of `stall_count`.
- REGADDR, 5, register address width.

Ports:
- `clk`  in  1  pipeline clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID stage holds a real instruction.
- `id_rs`  in  REGADDR  ID source register 1.
- `id_rt`  in  REGADDR  ID source register 2.
- `id_uses_rs`  in  1  instruction reads `rs`.
- `id_uses_rt`  in  1  instruction reads `rt`.
- `id_rd`  in  REGADDR  ID destination register.
- `id_writes_reg`  in  1  instruction writes `id_rd`.
- `id_is_halt`  in  1  ID instruction is HALT.
- `branchTaken`  in  1  EX-stage branch/jump resolved taken.
- `hazardDetected`  out  1  freeze PC and IF/ID.
- `haltSignal`  out  1  freeze PC permanently.
- `flush_ifid`  out  1  clear IF/ID register.
- `bubble_idex`  out  1  load NOP into ID/EX.
- `pipe_done`  out  1  HALT has retired; pipeline empty.
- `stall_count`  out  DATA  total stall cycles.

Behaviour:
- Reset (async, `reset_n`=0):
  - Scoreboard entries cleared (valid=0, halt=0).
  - State=RUN.
  - `haltSignal`=0, `pipe_done`=0, `stall_count`=0.
  - Combinational outputs evaluate to 0 (`hazardDetected` qualified by an empty scoreboard).
  - Reset mid-drain or mid-stall returns to RUN immediately.
- Scoreboard entry: {wr, rd, halt}. A match requires `wr`=1, `rd`!=0 and `rd` equal to an active source (`id_uses_*`=1).
- `hazardDetected` (combinational):
  - Asserted when `id_valid` AND state=RUN AND !`branchTaken` AND the ID sources match the EX entry or the MEM entry.
  - The WB entry never causes a hazard: the register file writes in the first half-cycle and is read in the second.
  - Stall length is therefore 2 cycles for an EX dependency and 1 cycle for a MEM dependency.
- `flush_ifid` = `branchTaken` AND state=RUN.
- `bubble_idex` = `hazardDetected` OR `flush_ifid` OR state!=RUN.
- Priority: `branchTaken` overrides hazard and HALT issue. The ID instruction is wrong-path: no stall, no issue, HALT ignored.
- Issue condition: `id_valid` AND state=RUN AND !`hazardDetected` AND !`branchTaken`.
- Scoreboard update, each posedge:
  - EX <= issue ? {`id_writes_reg` && `id_rd`!=0 && !`id_is_halt`, `id_rd`, `id_is_halt`} : empty.
  - MEM <= EX.
  - WB <= MEM.
- FSM:
  - RUN -> DRAIN when issue && `id_is_halt`. `haltSignal` is registered and goes 1 in the same edge.
  - DRAIN -> HALTED on the edge after the halt token reaches WB (WB.halt=1).
  - HALTED is terminal until reset. `pipe_done`=1 (registered) in HALTED.
- In DRAIN/HALTED:
  - `haltSignal` stays 1.
  - No new issue; EX receives empty entries; the scoreboard keeps shifting so older instructions retire.
  - `hazardDetected`=0 and `branchTaken` is ignored.
- HALT timing: HALT issued at edge N puts the token in EX at N, MEM at N+1 and WB at N+2. State becomes HALTED and `pipe_done` rises at edge N+3.
- `stall_count`: +1 per cycle `hazardDetected`=1 at posedge; saturates at all-ones (no wrap).
- Register 0 is never a hazard source, whatever the decoded fields say.

Test Plan:
1. Reset, then `add r3` issued, next cycle `sub` reading `rs`=r3 -> `hazardDetected`=1 for exactly 2 cycles, `bubble_idex`=1 both cycles, issue on the 3rd; `stall_count`=2.
2. `lw r5` issued, one unrelated instruction, then reader of `rt`=r5 -> 1 stall cycle. A reader 3 instructions later -> 0 stalls (WB case).
3. Writer to r0 followed by reader of r0 -> no stall. Reader with `id_uses_rs`=0 but matching `id_rs` -> no stall.
4. Hazard present and `branchTaken`=1 in the same cycle -> `hazardDetected`=0, `flush_ifid`=1, `bubble_idex`=1, EX entry empty next cycle.
5. HALT in ID with `id_valid`=1 at edge N -> `haltSignal`=1 after N and held; `pipe_done` rises after edge N+3. HALT in ID with `branchTaken`=1 -> `haltSignal` stays 0.
6. `reset_n` pulsed low during DRAIN -> `haltSignal`, `pipe_done` and `stall_count` = 0 asynchronously. Force `stall_count` to all-ones minus 1 and stall 3 cycles -> value holds at all-ones.
